dtc_stub_scheduler: RTL and testbench
=====================================

// Module: dtc_stub_scheduler
// PURPOSE
//  Sequences the unpacking of one 256-bit CIC packet word from the capture register.
//  Each packet holds 10 stubs of 21 bits. The block routes every stub, by its 3-bit chipID,
//  into one of the 8 per-chip MPA BRAMs (7-bit address, 21-bit data).
//  It owns the per-chip write-address counters and flags overflow per chip.
//  Sits between the receive capture register and the mpa_0..mpa_7 BRAM ports.
// PARAMETERS
//  NUM_CHIPS     8    number of MPA BRAMs / chipID values
//  STUBS_PER_PKT 10   stubs extracted per packet
//  STUB_W        21   stub width
//  ADDR_W        7    MPA BRAM address width (depth 2**ADDR_W = 128)
//  PKT_W         256  packet word width
//  STUB0_MSB     229  MSB of stub 0; stub k = pkt[STUB0_MSB-k*STUB_W -: STUB_W]
//  CHIPID_LSB    15   chipID = stub[CHIPID_LSB+2:CHIPID_LSB]
// PORTS
//  clk        in   1                    system clock
//  rst_n      in   1                    synchronous reset, active low
//  pkt_valid  in   1                    pkt_data holds a new packet
//  pkt_ready  out  1                    scheduler can accept a packet
//  pkt_data   in   PKT_W                captured CIC packet word
//  evt_clear  in   1                    start of new event: zero counters/flags, abort packet
//  wr_en      out  NUM_CHIPS            one-hot BRAM write strobe (wea)
//  wr_addr    out  NUM_CHIPS*ADDR_W     per-chip write address, chip c at [c*ADDR_W +: ADDR_W]
//  wr_data    out  STUB_W               stub data, shared by all BRAMs
//  fill_level out  NUM_CHIPS*(ADDR_W+1) per-chip stored-stub count, 0..128
//  overflow   out  NUM_CHIPS            sticky: a stub was dropped because its BRAM was full
//  pkt_done   out  1                    1-cycle pulse: all stubs of a packet processed
//  busy       out  1                    FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): FSM=IDLE. wr_en, wr_addr, wr_data, fill_level, overflow,
//   pkt_done and busy are all 0. pkt_ready is forced to 0 while rst_n=0.
//  pkt_ready = (state==IDLE) & ~evt_clear & rst_n. This is combinational.
//  A packet is accepted when pkt_valid & pkt_ready are both 1 at a clk edge.
//   At that edge pkt_data is latched into pkt_q.
//  FSM states and transitions:
//   IDLE --accept--> EXTRACT, with idx=0.
//   EXTRACT: processes one stub per cycle. idx increments each cycle.
//    When idx==STUBS_PER_PKT-1 the next state is DONE.
//   DONE: one cycle, then IDLE.
//  Per-stub rule in EXTRACT, with s=stub idx and c=chipID(s):
//   s==0 (empty slot): skipped. No write, no counter change.
//   fill[c]==128: stub dropped and overflow[c] is set. No write.
//   Otherwise: wr_en[c]=1, wr_addr[c]=fill[c][ADDR_W-1:0], wr_data=s, and fill[c] increments.
//  Outputs are registered. wr_en is high for 1 cycle per stub.
//   wr_data and wr_addr are valid in the same cycle as wr_en.
//  Timing, for an accept edge at cycle T:
//   stub k's strobe (if any) is high in cycle T+2+k, for k=0..9.
//   pkt_done is high in cycle T+12.
//   pkt_ready is high again from cycle T+12, so back-to-back packets are 12 cycles apart.
//  busy = 1 from T+1 through T+11.
//  fill counters never wrap; they saturate at 128. overflow bits are cleared only by
//   evt_clear or reset.
//  evt_clear, sampled at a clk edge:
//   - zeroes fill_level and overflow;
//   - returns the FSM to IDLE with no pkt_done;
//   - suppresses any strobe due in the next cycle.
//   It has priority over pkt_valid, so no accept occurs while it is high.
//  Reset mid-packet has the same effect as evt_clear, plus all outputs return to 0.
//  Consecutive stubs with the same chipID get consecutive addresses.
// TESTING
//  1) Packet with chipIDs 0..7,0,1 (nonzero stubs), then idle.
//     -> 10 strobes in T+2..T+11; chips 0,1 get addr 0 then 1; fill={2,2,1,1,1,1,1,1}; pkt_done at T+12.
//  2) Stubs 3,5,7 all-zero, the other 7 stubs chipID 4.
//     -> 7 strobes to chip 4 at addr 0..6; no strobe in cycles T+5, T+7, T+9; fill[4]=7.
//  3) 13 packets of all chipID 2, then one more packet.
//     -> fill[2] stops at 128 (addr 127 is written); remaining stubs dropped; overflow[2]=1; other bits 0.
//  4) evt_clear asserted in cycle T+5.
//     -> no strobes after T+5; no pkt_done; fill=0, overflow=0; pkt_ready=1 in T+6.
//  5) pkt_valid held high for 3 packets.
//     -> accepts at T, T+12, T+24; each pkt_done exactly once.
//     evt_clear and pkt_valid high together in IDLE -> no accept.
//  6) rst_n low for 1 cycle at T+8.
//     -> all outputs 0 next cycle; FSM IDLE; a new packet afterwards writes chip addresses from 0.

Source files
------------

// File: rtl/dtc_stub_scheduler.sv
// Unpacks one CIC packet word into ten stubs and routes each stub
// to its per-chip MPA BRAM, tracking fill levels and overflow.
module dtc_stub_scheduler #(
    parameter int NUM_CHIPS     = 8,
    parameter int STUBS_PER_PKT = 10,
    parameter int STUB_W        = 21,
    parameter int ADDR_W        = 7,
    parameter int PKT_W         = 256,
    parameter int STUB0_MSB     = 229,
    parameter int CHIPID_LSB    = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pkt_valid,
    output logic                            pkt_ready,
    input  logic [PKT_W-1:0]                pkt_data,
    input  logic                            evt_clear,
    output logic [NUM_CHIPS-1:0]            wr_en,
    output logic [NUM_CHIPS*ADDR_W-1:0]     wr_addr,
    output logic [STUB_W-1:0]               wr_data,
    output logic [NUM_CHIPS*(ADDR_W+1)-1:0] fill_level,
    output logic [NUM_CHIPS-1:0]            overflow,
    output logic                            pkt_done,
    output logic                            busy
);

    localparam int IDX_W  = $clog2(STUBS_PER_PKT);
    localparam int CID_W  = $clog2(NUM_CHIPS);
    localparam int FILL_W = ADDR_W + 1;
    localparam int BODY_W = STUBS_PER_PKT * STUB_W;
    localparam int BODY_LSB = STUB0_MSB - BODY_W + 1;

    localparam logic [FILL_W-1:0] FULL =
        FILL_W'(2 ** ADDR_W);
    localparam logic [IDX_W-1:0] LAST =
        IDX_W'(STUBS_PER_PKT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXTRACT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]          state;
    logic [IDX_W-1:0]    idx;
    logic [BODY_W-1:0]   pkt_q;
    logic [STUB_W-1:0]   stub_arr [STUBS_PER_PKT];
    logic [STUB_W-1:0]   cur_stub;
    logic [CID_W-1:0]    cur_chip;
    logic [FILL_W-1:0]   cur_fill;
    logic [FILL_W-1:0]   fill_q [NUM_CHIPS];
    logic [ADDR_W-1:0]   addr_q [NUM_CHIPS];
    logic                unused_bits;

    // Only the stub body of the packet word is kept.
    assign unused_bits = ^{pkt_data[PKT_W-1:STUB0_MSB+1],
                           pkt_data[BODY_LSB-1:0]};

    assign pkt_ready = (state == S_IDLE) & ~evt_clear & rst_n;
    assign busy      = (state != S_IDLE);

    for (genvar k = 0; k < STUBS_PER_PKT; k++) begin : g_stub
        assign stub_arr[k] =
            pkt_q[BODY_W-1-k*STUB_W -: STUB_W];
    end

    for (genvar c = 0; c < NUM_CHIPS; c++) begin : g_chip
        assign wr_addr[c*ADDR_W +: ADDR_W]    = addr_q[c];
        assign fill_level[c*FILL_W +: FILL_W] = fill_q[c];
    end

    assign cur_stub = stub_arr[idx];
    assign cur_chip = cur_stub[CHIPID_LSB +: CID_W];
    assign cur_fill = fill_q[cur_chip];

    always_ff @(posedge clk) begin
        if (pkt_valid && pkt_ready) begin
            pkt_q <= pkt_data[STUB0_MSB -: BODY_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            wr_en    <= '0;
            wr_data  <= '0;
            overflow <= '0;
            pkt_done <= 1'b0;
            for (int c = 0; c < NUM_CHIPS; c++) begin
                fill_q[c] <= '0;
                addr_q[c] <= '0;
            end
        end else if (evt_clear) begin
            state    <= S_IDLE;
            idx      <= '0;
            wr_en    <= '0;
            overflow <= '0;
            pkt_done <= 1'b0;
            for (int c = 0; c < NUM_CHIPS; c++) begin
                fill_q[c] <= '0;
            end
        end else begin
            wr_en    <= '0;
            pkt_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pkt_valid) begin
                        state <= S_EXTRACT;
                        idx   <= '0;
                    end
                end
                S_EXTRACT: begin
                    // All-zero stubs are empty slots.
                    if (|cur_stub) begin
                        if (cur_fill == FULL) begin
                            overflow[cur_chip] <= 1'b1;
                        end else begin
                            wr_en[cur_chip]  <= 1'b1;
                            addr_q[cur_chip] <=
                                cur_fill[ADDR_W-1:0];
                            wr_data          <= cur_stub;
                            fill_q[cur_chip] <=
                                cur_fill + FILL_W'(1);
                        end
                    end
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    pkt_done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_stub_scheduler.sv
// Directed bench for dtc_stub_scheduler: routing, skips,
// saturation, evt_clear, back-to-back packets and reset.
module tb_dtc_stub_scheduler;

    logic         clk;
    logic         rst_n;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [255:0] pkt_data;
    logic         evt_clear;
    logic [7:0]   wr_en;
    logic [55:0]  wr_addr;
    logic [20:0]  wr_data;
    logic [63:0]  fill_level;
    logic [7:0]   overflow;
    logic         pkt_done;
    logic         busy;

    int tests;
    int fails;

    logic [7:0]  cap_en   [13];
    logic [55:0] cap_addr [13];
    logic [20:0] cap_data [13];
    logic        cap_done [13];
    logic        cap_busy [13];
    logic        cap_ready0;

    dtc_stub_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .evt_clear  (evt_clear),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fill_level (fill_level),
        .overflow   (overflow),
        .pkt_done   (pkt_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] mk_stub(
        input int chip, input int tag);
        logic [20:0] s;
        s = '0;
        s[17:15] = chip[2:0];
        s[14:0]  = tag[14:0];
        return s;
    endfunction

    function automatic logic [255:0] put_stub(
        input logic [255:0] p, input int k,
        input logic [20:0] s);
        logic [255:0] r;
        r = p;
        r[229-k*21 -: 21] = s;
        return r;
    endfunction

    function automatic logic [255:0] pkt_all(input int chip);
        logic [255:0] p;
        p = '0;
        for (int k = 0; k < 10; k++)
            p = put_stub(p, k, mk_stub(chip, 100 + k));
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_evt();
        evt_clear = 1'b1;
        step();
        evt_clear = 1'b0;
    endtask

    task automatic capture(input logic [255:0] p);
        pkt_data  = p;
        pkt_valid = 1'b1;
        #1;
        cap_ready0 = pkt_ready;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j == 1) pkt_valid = 1'b0;
            cap_en[j]   = wr_en;
            cap_addr[j] = wr_addr;
            cap_data[j] = wr_data;
            cap_done[j] = pkt_done;
            cap_busy[j] = busy;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests++;
        if (pkt_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready got %b want 0", pkt_ready);
        end
        tests++;
        if ({wr_en, wr_addr, wr_data, fill_level, overflow,
             pkt_done, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got en=%h addr=%h data=%h fill=%h ovf=%h done=%b busy=%b want all 0",
                     wr_en, wr_addr, wr_data, fill_level,
                     overflow, pkt_done, busy);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (pkt_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready got %b want 1",
                     pkt_ready);
        end
    endtask

    task automatic test_routing();
        logic [255:0] p;
        logic [20:0]  sv [10];
        int           chip;
        int           want;
        p = '0;
        for (int k = 0; k < 10; k++) begin
            sv[k] = mk_stub(k % 8, k + 1);
            p = put_stub(p, k, sv[k]);
        end
        clear_evt();
        capture(p);
        tests++;
        if (cap_ready0 !== 1'b1) begin
            fails++;
            $display("FAIL route_ready got %b want 1", cap_ready0);
        end
        for (int k = 0; k < 10; k++) begin
            chip = k % 8;
            want = (k >= 8) ? 1 : 0;
            tests++;
            if (cap_en[2+k] !== 8'(1 << chip) ||
                cap_data[2+k] !== sv[k] ||
                cap_addr[2+k][chip*7 +: 7] !== 7'(want)) begin
                fails++;
                $display("FAIL route_stub%0d got en=%h data=%h addr=%0d want en=%h data=%h addr=%0d",
                         k, cap_en[2+k], cap_data[2+k],
                         cap_addr[2+k][chip*7 +: 7],
                         8'(1 << chip), sv[k], want);
            end
        end
        tests++;
        if (cap_en[1] !== 8'h00 || cap_en[12] !== 8'h00) begin
            fails++;
            $display("FAIL route_edges got en1=%h en12=%h want 0 0",
                     cap_en[1], cap_en[12]);
        end
        for (int j = 1; j <= 12; j++) begin
            tests++;
            if (cap_done[j] !== (j == 12) ||
                cap_busy[j] !== (j <= 11)) begin
                fails++;
                $display("FAIL route_ctl_c%0d got done=%b busy=%b want done=%b busy=%b",
                         j, cap_done[j], cap_busy[j],
                         (j == 12), (j <= 11));
            end
        end
        for (int c = 0; c < 8; c++) begin
            want = (c < 2) ? 2 : 1;
            tests++;
            if (fill_level[c*8 +: 8] !== 8'(want)) begin
                fails++;
                $display("FAIL route_fill%0d got %0d want %0d",
                         c, fill_level[c*8 +: 8], want);
            end
        end
    endtask

    task automatic test_skip();
        logic [255:0] p;
        int           a;
        p = '0;
        for (int k = 0; k < 10; k++)
            if (k != 3 && k != 5 && k != 7)
                p = put_stub(p, k, mk_stub(4, 200 + k));
        clear_evt();
        capture(p);
        a = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3 || k == 5 || k == 7) begin
                tests++;
                if (cap_en[2+k] !== 8'h00) begin
                    fails++;
                    $display("FAIL skip_empty%0d got en=%h want 00",
                             k, cap_en[2+k]);
                end
            end else begin
                tests++;
                if (cap_en[2+k] !== 8'h10 ||
                    cap_addr[2+k][28 +: 7] !== 7'(a)) begin
                    fails++;
                    $display("FAIL skip_stub%0d got en=%h addr=%0d want en=10 addr=%0d",
                             k, cap_en[2+k],
                             cap_addr[2+k][28 +: 7], a);
                end
                a++;
            end
        end
        tests++;
        if (fill_level !== 64'h0000_0007_0000_0000) begin
            fails++;
            $display("FAIL skip_fill got %h want 0000000700000000",
                     fill_level);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] any_en;
        clear_evt();
        for (int n = 1; n <= 13; n++) begin
            capture(pkt_all(2));
            if (n == 12) begin
                tests++;
                if (fill_level[16 +: 8] !== 8'd120 ||
                    overflow !== 8'h00) begin
                    fails++;
                    $display("FAIL sat_pre got fill=%0d ovf=%h want 120 00",
                             fill_level[16 +: 8], overflow);
                end
            end
        end
        tests++;
        if (cap_en[9] !== 8'h04 ||
            cap_addr[9][14 +: 7] !== 7'd127) begin
            fails++;
            $display("FAIL sat_last got en=%h addr=%0d want 04 127",
                     cap_en[9], cap_addr[9][14 +: 7]);
        end
        tests++;
        if (cap_en[10] !== 8'h00 || cap_en[11] !== 8'h00) begin
            fails++;
            $display("FAIL sat_drop got en10=%h en11=%h want 00 00",
                     cap_en[10], cap_en[11]);
        end
        tests++;
        if (fill_level[16 +: 8] !== 8'd128 ||
            overflow !== 8'h04) begin
            fails++;
            $display("FAIL sat_full got fill=%0d ovf=%h want 128 04",
                     fill_level[16 +: 8], overflow);
        end
        capture(pkt_all(2));
        any_en = '0;
        for (int j = 1; j <= 12; j++) any_en |= cap_en[j];
        tests++;
        if (any_en !== 8'h00 || fill_level[16 +: 8] !== 8'd128 ||
            overflow !== 8'h04 || cap_done[12] !== 1'b1) begin
            fails++;
            $display("FAIL sat_extra got en=%h fill=%0d ovf=%h done=%b want 00 128 04 1",
                     any_en, fill_level[16 +: 8], overflow,
                     cap_done[12]);
        end
    endtask

    task automatic test_evt_clear();
        logic [7:0] any_en;
        logic       any_done;
        pkt_data  = pkt_all(1);
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        for (int j = 2; j <= 5; j++) step();
        tests++;
        if (wr_en !== 8'h02) begin
            fails++;
            $display("FAIL clr_before got en=%h want 02", wr_en);
        end
        evt_clear = 1'b1;
        step();
        evt_clear = 1'b0;
        #1;
        tests++;
        if (wr_en !== 8'h00 || fill_level !== '0 ||
            overflow !== 8'h00) begin
            fails++;
            $display("FAIL clr_state got en=%h fill=%h ovf=%h want 0",
                     wr_en, fill_level, overflow);
        end
        tests++;
        if (pkt_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clr_idle got ready=%b busy=%b want 1 0",
                     pkt_ready, busy);
        end
        any_en   = '0;
        any_done = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            any_en   |= wr_en;
            any_done |= pkt_done;
        end
        tests++;
        if (any_en !== 8'h00 || any_done !== 1'b0) begin
            fails++;
            $display("FAIL clr_after got en=%h done=%b want 00 0",
                     any_en, any_done);
        end
    endtask

    task automatic test_back_to_back();
        int strobes;
        logic want;
        clear_evt();
        pkt_data  = pkt_all(3);
        pkt_valid = 1'b1;
        strobes   = 0;
        for (int j = 1; j <= 36; j++) begin
            step();
            strobes += $countones(wr_en);
            want = (j % 12 == 0);
            tests++;
            if (pkt_done !== want || busy !== !want) begin
                fails++;
                $display("FAIL b2b_c%0d got done=%b busy=%b want done=%b busy=%b",
                         j, pkt_done, busy, want, !want);
            end
            if (j == 36) pkt_valid = 1'b0;
        end
        tests++;
        if (strobes != 30 || fill_level[24 +: 8] !== 8'd30) begin
            fails++;
            $display("FAIL b2b_count got strobes=%0d fill=%0d want 30 30",
                     strobes, fill_level[24 +: 8]);
        end
        pkt_valid = 1'b1;
        evt_clear = 1'b1;
        #1;
        tests++;
        if (pkt_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_clr_ready got %b want 0", pkt_ready);
        end
        step();
        pkt_valid = 1'b0;
        evt_clear = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_clr_accept got busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        clear_evt();
        pkt_data  = pkt_all(5);
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        for (int j = 2; j <= 8; j++) step();
        rst_n = 1'b0;
        step();
        tests++;
        if ({wr_en, wr_addr, wr_data, fill_level, overflow,
             pkt_done, busy, pkt_ready} !== '0) begin
            fails++;
            $display("FAIL mrst_outputs got en=%h addr=%h data=%h fill=%h ovf=%h done=%b busy=%b ready=%b want all 0",
                     wr_en, wr_addr, wr_data, fill_level,
                     overflow, pkt_done, busy, pkt_ready);
        end
        rst_n = 1'b1;
        capture(pkt_all(5));
        tests++;
        if (cap_en[2] !== 8'h20 ||
            cap_addr[2][35 +: 7] !== 7'd0 ||
            cap_addr[11][35 +: 7] !== 7'd9) begin
            fails++;
            $display("FAIL mrst_restart got en=%h a0=%0d a9=%0d want 20 0 9",
                     cap_en[2], cap_addr[2][35 +: 7],
                     cap_addr[11][35 +: 7]);
        end
        tests++;
        if (fill_level !== 64'h0000_0A00_0000_0000) begin
            fails++;
            $display("FAIL mrst_fill got %h want 00000A0000000000",
                     fill_level);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        evt_clear = 1'b0;
        test_reset();
        test_routing();
        test_skip();
        test_saturate();
        test_evt_clear();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
